// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FETCH/EXEC/MEM control FSM driving PC, IR, regfile, ALU and data memory
module control_sequencer #(
  parameter int Osize = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Osize-1:0] Opcode,
  input  logic             Zflag,
  input  logic             MemReady,
  output logic             IRload,
  output logic             PCincr,
  output logic             PCrelbranch,
  output logic             RegWrite,
  output logic [2:0]       ALUop,
  output logic             ImmSel,
  output logic             MemtoReg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Halted
);
  typedef enum logic [2:0] {RST, FETCH, EXEC, MEM, HALT} state_t;
  state_t state, next;
  logic is_st;
  logic [3:0] op;
  assign op = Opcode[3:0];
  // is_st remembers whether the pending memory access is a store
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= RST;
      is_st <= 1'b0;
    end else begin
      state <= next;
      if (state == EXEC) is_st <= (op == 4'd9);
    end
  always_comb begin
    next = state;
    IRload = 1'b0;
    PCincr = 1'b0;
    PCrelbranch = 1'b0;
    RegWrite = 1'b0;
    ALUop = 3'd0;
    ImmSel = 1'b0;
    MemtoReg = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    Halted = 1'b0;
    case (state)
      RST: next = FETCH;
      FETCH: begin
        IRload = 1'b1;
        next = EXEC;
      end
      EXEC: begin
        next = FETCH;
        case (op)
          4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
            RegWrite = 1'b1;
            ALUop = 3'(op - 4'd1);
            PCincr = 1'b1;
          end
          4'd6: begin
            RegWrite = 1'b1;
            ImmSel = 1'b1;
            ALUop = 3'd5;
            PCincr = 1'b1;
          end
          4'd7: begin
            RegWrite = 1'b1;
            ALUop = 3'd5;
            PCincr = 1'b1;
          end
          4'd8: begin
            MemRead = 1'b1;
            ImmSel = 1'b1;
            next = MEM;
          end
          4'd9: begin
            MemWrite = 1'b1;
            ImmSel = 1'b1;
            next = MEM;
          end
          4'd10: begin
            PCrelbranch = Zflag;
            PCincr = !Zflag;
          end
          4'd11: begin
            PCrelbranch = !Zflag;
            PCincr = Zflag;
          end
          4'd12: PCrelbranch = 1'b1;
          4'd15: next = HALT;
          default: PCincr = 1'b1;
        endcase
      end
      MEM: begin
        MemRead = !is_st;
        MemWrite = is_st;
        ImmSel = 1'b1;
        if (MemReady) begin
          RegWrite = !is_st;
          MemtoReg = !is_st;
          PCincr = 1'b1;
          next = FETCH;
        end
      end
      HALT: Halted = 1'b1;
      default: next = RST;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed vectors with hand-computed expected control words
module tb_control_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] Opcode = 4'd0;
  logic Zflag = 1'b0;
  logic MemReady = 1'b0;
  logic IRload, PCincr, PCrelbranch, RegWrite, ImmSel, MemtoReg, MemRead, MemWrite, Halted;
  logic [2:0] ALUop;
  logic [11:0] outs;
  int n_cmp = 0;
  int n_err = 0;
  localparam logic [11:0] IR = 12'h800, PI = 12'h400, PB = 12'h200, RW = 12'h100;
  localparam logic [11:0] IMM = 12'h010, M2R = 12'h008, MR = 12'h004, MW = 12'h002, H = 12'h001;
  control_sequencer #(.Osize(4)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zflag(Zflag), .MemReady(MemReady),
    .IRload(IRload), .PCincr(PCincr), .PCrelbranch(PCrelbranch), .RegWrite(RegWrite),
    .ALUop(ALUop), .ImmSel(ImmSel), .MemtoReg(MemtoReg), .MemRead(MemRead),
    .MemWrite(MemWrite), .Halted(Halted)
  );
  assign outs = {IRload, PCincr, PCrelbranch, RegWrite, ALUop, ImmSel, MemtoReg, MemRead, MemWrite, Halted};
  always #5 clk = ~clk;
  function automatic logic [11:0] alu(input int n);
    return 12'(n) << 5;
  endfunction
  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) check("excl", {11'd0, PCincr & PCrelbranch}, 12'd0);
  logic [3:0] ops[19];
  logic zfs[19];
  logic [11:0] exps[19];
  initial begin
    ops  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd0, 4'd13, 4'd14,
             4'd10, 4'd10, 4'd11, 4'd11, 4'd12, 4'd12, 4'd1, 4'd6, 4'd0};
    zfs  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
             1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exps = '{RW | alu(0) | PI, RW | alu(1) | PI, RW | alu(2) | PI, RW | alu(3) | PI,
             RW | alu(4) | PI, RW | IMM | alu(5) | PI, RW | alu(5) | PI, PI, PI, PI,
             PB, PI, PI, PB, PB, PB, RW | alu(0) | PI, RW | IMM | alu(5) | PI, PI};
    repeat (3) begin
      step();
      check("rst_hold", outs, 12'd0);
    end
    reset = 1'b1;
    check("rst_release", outs, 12'd0);
    step();
    check("fetch0", outs, IR);
    for (int i = 0; i < 19; i++) begin
      Opcode = ops[i];
      Zflag = zfs[i];
      MemReady = 1'(i % 2);
      step();
      check($sformatf("exec_op%0d_z%0d", ops[i], zfs[i]), outs, exps[i]);
      step();
      check("fetch", outs, IR);
    end
    Opcode = 4'd8;
    MemReady = 1'b0;
    step();
    check("ld_exec", outs, MR | IMM);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("ld_stall%0d", i), outs, MR | IMM);
    end
    step();
    MemReady = 1'b1;
    #1;
    check("ld_done", outs, MR | IMM | RW | M2R | PI);
    step();
    MemReady = 1'b0;
    check("ld_fetch", outs, IR);
    Opcode = 4'd9;
    MemReady = 1'b1;
    step();
    check("st_exec", outs, MW | IMM);
    MemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("st_stall%0d", i), outs, MW | IMM);
    end
    step();
    MemReady = 1'b1;
    #1;
    check("st_done", outs, MW | IMM | PI);
    step();
    MemReady = 1'b0;
    check("st_fetch", outs, IR);
    Opcode = 4'd8;
    step();
    check("ldr_exec", outs, MR | IMM);
    step();
    check("ldr_stall1", outs, MR | IMM);
    step();
    check("ldr_stall2", outs, MR | IMM);
    #2 reset = 1'b0;
    #1;
    check("ldr_async", outs, 12'd0);
    MemReady = 1'b1;
    step();
    check("ldr_held", outs, 12'd0);
    MemReady = 1'b0;
    reset = 1'b1;
    step();
    check("ldr_fetch", outs, IR);
    Opcode = 4'd15;
    step();
    check("halt_exec", outs, 12'd0);
    for (int i = 0; i < 20; i++) begin
      MemReady = 1'(i % 2);
      Zflag = 1'(i % 3 == 0);
      step();
      check($sformatf("halted%0d", i), outs, H);
    end
    reset = 1'b0;
    #1;
    check("halt_rst", outs, 12'd0);
    step();
    reset = 1'b1;
    step();
    check("halt_fetch", outs, IR);
    Opcode = 4'd14;
    step();
    check("nop14_exec", outs, PI);
    step();
    check("nop14_fetch", outs, IR);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
